// File: rtl/instr_loader_hdu_if.sv
// rtl/instr_loader_hdu_if.sv - switch/button inputs and image/hazard outputs of the loader
interface instr_loader_hdu_if #(
    parameter int W     = 8,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]       input_val;
    logic               but_inp;
    logic               but_check;
    logic [DEPTH*W-1:0] instrMemBits;
    logic [DEPTH-1:0]   hazardMemBits;
    logic [CW-1:0]      count;
    logic               full;
    logic               busy;
    logic               done;

    modport master (
        output input_val, but_inp, but_check,
        input  instrMemBits, hazardMemBits, count, full, busy, done
    );

    modport slave (
        input  input_val, but_inp, but_check,
        output instrMemBits, hazardMemBits, count, full, busy, done
    );
endinterface

// File: rtl/instr_loader_hdu.sv
// rtl/instr_loader_hdu.sv - button-driven instruction image loader with RAW hazard scan
module instr_loader_hdu #(
    parameter int W          = 8,
    parameter int DEPTH      = 8,
    parameter int HAZ_DIST   = 2,
    parameter int DEB_CYCLES = 0
) (
    input logic              clk,
    input logic              rst,
    instr_loader_hdu_if.slave bus
);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DCW = (DEB_CYCLES > 0) ? $clog2(DEB_CYCLES + 1) : 1;
    localparam logic [DCW-1:0] DEB_MAX = DCW'(DEB_CYCLES);

    localparam logic [1:0] LOAD = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Button index 0 is but_inp, index 1 is but_check.
    logic [1:0]     btn;
    logic [1:0]     sync1;
    logic [1:0]     sync2;
    logic [1:0]     filt;
    logic [1:0]     flip;
    logic [DCW-1:0] deb_cnt [2];
    logic           primed;
    logic           ev_inp;
    logic           ev_chk;

    logic [1:0]       state;
    logic [W-1:0]     slots [DEPTH];
    logic [CW-1:0]    count;
    logic [CW-1:0]    idx;
    logic [DEPTH-1:0] hazard;
    logic             hit;
    logic             load_ok;
    logic [W-1:0]     cur;
    logic [W-1:0]     prv;

    assign btn = {bus.but_check, bus.but_inp};

    // Synchroniser keeps sampling during reset so a held button is seen correctly at reset exit.
    always_ff @(posedge clk) begin
        sync1 <= btn;
        sync2 <= sync1;
    end

    always_comb begin
        flip = '0;
        for (int b = 0; b < 2; b++)
            flip[b] = primed && (sync2[b] != filt[b]) && (deb_cnt[b] == DEB_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt       <= '0;
            primed     <= 1'b0;
            ev_inp     <= 1'b0;
            ev_chk     <= 1'b0;
            deb_cnt[0] <= '0;
            deb_cnt[1] <= '0;
        end else if (!primed) begin
            filt       <= sync2;
            primed     <= 1'b1;
            ev_inp     <= 1'b0;
            ev_chk     <= 1'b0;
            deb_cnt[0] <= '0;
            deb_cnt[1] <= '0;
        end else begin
            ev_inp <= flip[0];
            ev_chk <= flip[1] & sync2[1];
            for (int b = 0; b < 2; b++) begin
                if (sync2[b] == filt[b] || flip[b])
                    deb_cnt[b] <= '0;
                else
                    deb_cnt[b] <= deb_cnt[b] + 1'b1;
                if (flip[b])
                    filt[b] <= sync2[b];
            end
        end
    end

    // A slot within HAZ_DIST behind idx conflicts if it writes a register idx touches.
    always_comb begin
        hit = 1'b0;
        prv = '0;
        cur = slots[idx[AW-1:0]];
        for (int k = 1; k <= HAZ_DIST; k++) begin
            if (int'(idx) >= k) begin
                prv = slots[idx[AW-1:0] - AW'(k)];
                if (prv[W-1:W-2] != 2'b11 &&
                    (prv[W-3:W-5] == cur[W-3:W-5] || prv[W-3:W-5] == cur[W-6:W-8]))
                    hit = 1'b1;
            end
        end
    end

    assign load_ok = ev_inp && (state != SCAN) && (count != CW'(DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= LOAD;
            count  <= '0;
            idx    <= '0;
            hazard <= '0;
            for (int i = 0; i < DEPTH; i++)
                slots[i] <= '0;
        end else begin
            case (state)
                SCAN: begin
                    if (idx == count) begin
                        state <= DONE;
                    end else begin
                        hazard[idx[AW-1:0]] <= hit;
                        idx                 <= idx + 1'b1;
                    end
                end
                default: begin
                    if (load_ok) begin
                        slots[count[AW-1:0]] <= bus.input_val;
                        count                <= count + 1'b1;
                        hazard               <= '0;
                        state                <= LOAD;
                    end else if (ev_chk) begin
                        state  <= SCAN;
                        idx    <= '0;
                        hazard <= '0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        bus.instrMemBits = '0;
        for (int i = 0; i < DEPTH; i++)
            bus.instrMemBits[i*W +: W] = slots[i];
    end

    assign bus.hazardMemBits = hazard;
    assign bus.count         = count;
    assign bus.full          = (count == CW'(DEPTH));
    assign bus.busy          = (state == SCAN);
    assign bus.done          = (state == DONE);
endmodule

// File: doc/instr_loader_hdu.md
Name: instr_loader_hdu

Overview:
- Parametrised successor to the 8-bit input-mode/check block.
- Bytes presented on input_val are captured into an instruction image on every debounced toggle of but_inp.
- A but_check request then scans the loaded program one instruction per cycle and flags RAW hazards within a configurable distance.
- Sits between board switches/buttons and the 5-stage core's instruction memory and hazard detection unit.

Parameters:
- W, 8, instruction/byte width; must be >= 8. Fields: [W-1:W-2] opcode, [W-3:W-5] rd, [W-6:W-8] rs.
- DEPTH, 8, number of instruction slots.
- HAZ_DIST, 2, number of preceding instructions examined for a RAW conflict; range 1..DEPTH-1.
- DEB_CYCLES, 0, consecutive stable cycles required before a button level is accepted; 0 means accepted immediately.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- input_val  in  W  instruction byte from switches.
- but_inp  in  1  load button, asynchronous; each level change loads one word.
- but_check  in  1  check request, asynchronous, level; acts on rising edge only.
- instrMemBits  out  DEPTH*W  slot i at [i*W +: W].
- hazardMemBits  out  DEPTH  bit i set when instruction i has a hazard.
- count  out  $clog2(DEPTH+1)  number of words loaded.
- full  out  1  count==DEPTH.
- busy  out  1  scan in progress.
- done  out  1  scan finished; held until rst or next load.

Behaviour:
- Reset values: instrMemBits=0, hazardMemBits=0, count=0, full=0, busy=0, done=0, state=LOAD, primed=0.
- Button conditioning:
  - Each button passes through a 2-FF synchroniser, then a debounce counter.
  - The filtered level follows the synced level once the synced level differs from it for DEB_CYCLES+1 consecutive cycles.
  - The first post-reset cycle copies the synced level into the filtered level with no event and sets primed. A button held high through reset therefore produces no load.
- Load (state LOAD):
  - Every filtered but_inp change (0->1 or 1->0) writes the current input_val into slot count, then increments count.
  - Write occurs the cycle after the filtered change. Worst-case pin-to-instrMemBits latency is DEB_CYCLES+4 clk.
  - input_val is sampled at that write cycle and must be stable.
  - When full=1, further toggles are ignored: count holds, no wrap.
  - Any accepted load clears done and hazardMemBits.
- Check:
  - A filtered rising edge of but_check in LOAD moves to SCAN: busy=1, i=0, hazardMemBits=0.
  - In SCAN, one instruction is evaluated per cycle for i=0..count-1, setting hazardMemBits[i].
  - The cycle after i=count-1 completes: go to DONE with busy=0, done=1.
  - If count=0, SCAN lasts one cycle, then DONE with hazardMemBits=0.
  - Scan latency: count+1 cycles from entering SCAN to done.
- Hazard rule:
  - Instruction j writes rd_j iff opcode_j != 2'b11.
  - Instruction i reads rd_i and rs_i.
  - hazardMemBits[i]=1 iff there exists j with max(0, i-HAZ_DIST) <= j < i, j writes, and rd_j==rd_i or rd_j==rs_i.
  - Bits i >= count are always 0.
- DONE:
  - An accepted load returns to LOAD, clears done, and appends to the existing image.
  - A new but_check rising edge rescans.
- Simultaneous events and mid-operation conditions:
  - Load and check events in the same cycle: the load is performed, the check is ignored.
  - but_inp toggles during SCAN are dropped, not queued.
  - but_check held high produces one scan only.
  - rst asserted mid-scan or mid-debounce: immediate return to reset values; partial results are discarded.

Test Plan:
- Defaults, toggle but_inp 8 times with CA, DC, 59, 9E, 00, 00, 00, 00 -> count=8, full=1, instrMemBits=64'h0000_0000_9E59_DCCA.
- Same image, pulse but_check -> busy for 9 cycles, then done=1, hazardMemBits=8'b1110_1000 (bit3: 9E after 59 on r3; bits5..7: r0 chain).
- With full=1, 3 further toggles with input_val=FF -> count stays 8, image unchanged, no wrap.
- Reset with but_inp held high, then release -> first falling toggle loads slot 0 only; no spurious load at reset exit.
- DEB_CYCLES=4, 3-cycle glitch on but_inp -> no load; 5-cycle stable change -> exactly one load.
- rst asserted when i=3 of a scan -> all outputs 0 next cycle. count=0 check -> done after 1 cycle with hazard=0.
